// File: rtl/uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_CLKS_PER_BIT  = 868;
  localparam logic UART_IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clk cycles and flags the last cycle of each bit.
// Clearing restarts the period so every state or bit begins at count zero.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO with combinational read data.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  if (DATA_WIDTH == 0) begin : gBadWidth
    $fatal(1, "fifo_uart_tx: DATA_WIDTH must be non-zero");
  end
  if (CLKS_PER_BIT < 2) begin : gBadBaud
    $fatal(1, "fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q;
  logic                  bitDone;
  logic                  baudClear;
  logic                  popReady;
  logic                  popEn;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Counter restarts whenever we leave or sit in IDLE so each bit is full length.
  assign baudClear = (state_q == IDLE) || (state_d != state_q);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBaud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baudClear),
    .bit_done(bitDone)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitIdx_d = bitIdx_q;
    tx_d     = tx_q;
    popReady = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d     = UART_IDLE_LEVEL;
        popReady = 1'b1;
      end
      START: begin
        if (bitDone) begin
          state_d  = DATA;
          bitIdx_d = '0;
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
        end
      end
      DATA: begin
        if (bitDone) begin
          if (bitIdx_q == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bitDone) begin
          state_d = STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        if (bitDone) begin
          popReady = 1'b1;
          state_d  = IDLE;
          tx_d     = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase

    // A pop overrides the IDLE/STOP outcome and starts the next frame at once.
    popEn = !rst && !fifo_empty && popReady;
    if (popEn) begin
      state_d  = START;
      tx_d     = 1'b0;
      shift_d  = fifo_rd_data;
      bitIdx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d = ^fifo_rd_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitIdx_q <= '0;
      tx_q     <= UART_IDLE_LEVEL;
      busy_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitIdx_q <= bitIdx_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = popEn;
  assign tx         = tx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model and per-cycle invariant checks.
// Expected serial frames are built from the payload byte, honouring FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  logic [7:0] mem [0:15];
  logic [4:0] rdPtr;
  logic [4:0] wrPtr;

  int checkCount;
  int passCount;
  int rdPulses;
  logic prevRd;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty   = (rdPtr == wrPtr);
  assign fifo_rd_data = mem[rdPtr[3:0]];

  // FIFO model read side: pop on the strobe, as a real synchronous FIFO would.
  always @(posedge clk) begin
    if (fifo_rd_en && (rdPtr != wrPtr)) begin
      rdPtr <= rdPtr + 5'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [7:0] data);
    mem[wrPtr[3:0]] = data;
    wrPtr = wrPtr + 5'd1;
  endtask

  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // One clock cycle: sample just after the falling edge and check invariants.
  task automatic tick();
    @(negedge clk);
    #1;
    checkOutput("rdEnDouble", {31'd0, prevRd & fifo_rd_en}, 32'd0);
    checkOutput("rdEnWhileEmpty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
    checkOutput("txHighWhenIdle", {31'd0, ~busy & ~tx}, 32'd0);
    if (fifo_rd_en) rdPulses++;
    prevRd = fifo_rd_en;
  endtask

  // Called in the cycle a word has just become available: expects the pop now.
  task automatic checkFrame(input logic [7:0] data, input string tag);
    #1;
    checkOutput({tag, "_rdEn"}, {31'd0, fifo_rd_en}, 32'd1);
    prevRd = fifo_rd_en;
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      tick();
      checkOutput({tag, "_tx"}, {31'd0, tx}, {31'd0, frameBit(data, i / CPB)});
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic applyStimulus();
    rst    = 1'b1;
    rdPtr  = 5'd0;
    wrPtr  = 5'd0;
    prevRd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("resetTx", {31'd0, tx}, 32'd1);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetRdEn", {31'd0, fifo_rd_en}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("emptyTx", {31'd0, tx}, 32'd1);
      checkOutput("emptyBusy", {31'd0, busy}, 32'd0);
      checkOutput("emptyRdEn", {31'd0, fifo_rd_en}, 32'd0);
    end

    // Single frame of 0xA5.
    rdPulses = 0;
    pushWord(8'hA5);
    checkFrame(8'hA5, "frameA5");
    checkOutput("a5ExtraPops", rdPulses, 32'd0);
    tick();
    checkOutput("a5BusyFall", {31'd0, busy}, 32'd0);
    checkOutput("a5TxIdle", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back 0x00 then 0xFF with no idle gap.
    rdPulses = 0;
    pushWord(8'h00);
    pushWord(8'hFF);
    checkFrame(8'h00, "frame00");
    checkFrame(8'hFF, "frameFF");
    checkOutput("b2bPopCount", rdPulses + 1, 32'd2);
    tick();
    checkOutput("b2bBusyFall", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) tick();

    // Parity-sensitive payloads (odd and even weight).
    pushWord(8'h07);
    checkFrame(8'h07, "frame07");
    tick();
    checkOutput("f07BusyFall", {31'd0, busy}, 32'd0);
    pushWord(8'h03);
    checkFrame(8'h03, "frame03");
    tick();
    checkOutput("f03BusyFall", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) tick();

    // Reset during data bit 3 of 0x5A with 0x3C queued behind it.
    pushWord(8'h5A);
    pushWord(8'h3C);
    #1;
    checkOutput("f5ARdEn", {31'd0, fifo_rd_en}, 32'd1);
    prevRd = fifo_rd_en;
    for (int i = 0; i < 4 * CPB + 2; i++) tick();
    checkOutput("f5ABit3", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midResetRdEn", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    checkOutput("midResetTx", {31'd0, tx}, 32'd1);
    checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    checkFrame(8'h3C, "frame3C");
    tick();
    checkOutput("f3CBusyFall", {31'd0, busy}, 32'd0);
    checkOutput("f3CFifoDrained", {31'd0, fifo_empty}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("finalIdleTx", {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rdPulses   = 0;
    applyStimulus();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
